mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for DIV/DIVU.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately).
REQ-005 Port start  input  1  E-stage valid strobe; op is acted on only when start=1.
REQ-006 Port op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-007 Port a  input  32  operand rs (forwarded value).
REQ-008 Port b  input  32  operand rt (forwarded value).
REQ-009 Port busy  output  1  registered; high while a multiply/divide is in flight.
REQ-010 Port hi  output  32  architectural HI register.
REQ-011 Port lo  output  32  architectural LO register.
REQ-012 Port rdata  output  32  combinational read: hi when op=MFHI, lo when op=MFLO, else 0 (independent of start).

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE, BUSY.
REQ-014 In IDLE, start=1 with op in {MULT,MULTU,DIV,DIVU} SHALL latch a, b, op and a down-counter loaded with MULT_CYCLES or DIV_CYCLES, and move to BUSY.
REQ-015 busy SHALL be 1 for exactly N consecutive cycles beginning the cycle after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 On the edge ending the Nth busy cycle, hi/lo SHALL update with the result and busy SHALL fall to 0 on that same edge; FSM returns to IDLE.
REQ-017 hi/lo SHALL hold their previous values throughout BUSY.
REQ-018 MULT: {hi,lo} SHALL equal the 64-bit two's-complement product of signed a and b.
REQ-019 MULTU: {hi,lo} SHALL equal the 64-bit unsigned product of a and b.
REQ-020 DIV: lo SHALL be the signed quotient truncated toward zero; hi SHALL be the remainder with the sign of a.
REQ-021 DIVU: lo SHALL be the unsigned quotient, hi the unsigned remainder.
REQ-022 DIV/DIVU with latched b=0 SHALL run the full DIV_CYCLES and leave hi/lo unchanged.
REQ-023 DIV with a=0x80000000, b=0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000.
REQ-024 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo respectively at the next edge, with no busy cycles.
REQ-025 Any start in BUSY (any op) SHALL be ignored; the in-flight operation SHALL complete unaffected and operand latches SHALL not change.
REQ-026 start with op NONE, MFHI or MFLO SHALL change no state.
REQ-027 Operands SHALL be sampled only at the accepting edge; a/b changes during BUSY SHALL not affect the result.
REQ-028 The pipeline controller stalls D when the D-stage instruction is an MDU op and (busy=1 or E-stage start with MULT..DIVU); mdu exposes busy for this, no extra port.

Reset
REQ-029 reset=0 SHALL asynchronously force state=IDLE, busy=0, counter=0, hi=0, lo=0, operand latches=0.
REQ-030 reset asserted during BUSY SHALL abort the operation; no result write occurs after release.
REQ-031 After reset release the block SHALL accept a start on the first rising edge.

Verification
REQ-032 MULT a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE as busy falls.
REQ-033 MULTU a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi/lo unchanged after 10 cycles.
REQ-035 MULT accepted, then start with MTLO a=0x12345678 on busy cycle 2 -> ignored; final lo is the MULT result; rdata with op=MFLO equals lo.
REQ-036 MTHI a=0xDEADBEEF -> hi=0xDEADBEEF next edge, busy stays 0; then DIV started, reset=0 at busy cycle 4 -> busy=0, hi=lo=0 immediately, no later update.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit: holds HI/LO, runs MULT/MULTU/DIV/DIVU over a fixed busy window, MTHI/MTLO write directly.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles after the accepting edge; MTHI/MTLO update at the next edge.
// Backpressure: busy stalls the issuing stage; any start seen while busy is dropped without side effects.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [3:0]  op_q;
  logic        busy_q;

  logic [31:0] hi_d, lo_d;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, dsr_u, dsr_m, q_m, r_m;

  // Result of the latched operation; computed from the latched operands only, committed on the final busy edge
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow special case
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    // Divisor forced to 1 when zero only to keep the dividers well defined; that result is discarded
    dsr_u  = (b_q == 32'd0) ? 32'd1 : b_q;
    dsr_m  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_m    = a_mag / dsr_m;
    r_m    = a_mag % dsr_m;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (op_q)
      OP_MULT: begin
        hi_d = prod_s[63:32];
        lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        hi_d = prod_u[63:32];
        lo_d = prod_u[31:0];
      end
      OP_DIV: begin
        if (b_q != 32'd0) begin
          lo_d = (a_q[31] ^ b_q[31]) ? (~q_m + 32'd1) : q_m;
          hi_d = a_q[31] ? (~r_m + 32'd1) : r_m;
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          lo_d = a_q / dsr_u;
          hi_d = a_q % dsr_u;
        end
      end
      default: ;
    endcase
  end

  // Control FSM: accept in IDLE, count down in BUSY, commit HI/LO and drop busy on the last busy edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                cnt_q   <= (op == OP_MULT || op == OP_MULTU) ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= S_BUSY;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cnt_q <= 16'd1) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Move-from read port: purely a function of op, so it works whether or not start is asserted
  always_comb begin
    rdata = 32'd0;
    if (op == OP_MFHI) rdata = hi_q;
    else if (op == OP_MFLO) rdata = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized bench for mdu with an arithmetic reference model of HI/LO and the busy window.
// Directed cases cover the listed corner results, a dropped start during busy, and reset mid-operation.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  int vectors;
  int miscompares;
  logic [31:0] exp_hi, exp_lo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_rdata();
    logic [3:0] sav;
    sav = op;
    op = 4'd5; #1 check("rdata_mfhi", rdata, exp_hi);
    op = 4'd6; #1 check("rdata_mflo", rdata, exp_lo);
    op = 4'd0; #1 check("rdata_none", rdata, 32'd0);
    op = sav;
  endtask

  // Issue one op at the next edge, follow its busy window, compare against the arithmetic model
  task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv, input bit inject);
    logic [63:0] p;
    longint sa, sb;
    logic [31:0] nh, nl;
    int n, cnt;
    nh = exp_hi; nl = exp_lo; n = 0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      4'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; n = MC; end
      4'd2: begin p = {32'd0, av} * {32'd0, bv}; nh = p[63:32]; nl = p[31:0]; n = MC; end
      4'd3: begin if (bv != 0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); end n = DC; end
      4'd4: begin if (bv != 0) begin nl = av / bv; nh = av % bv; end n = DC; end
      4'd7: nh = av;
      4'd8: nl = av;
      default: ;
    endcase
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
    if (n == 0) begin
      check("idle_busy", {31'd0, busy}, 32'd0);
    end else begin
      cnt = 0;
      while (busy && cnt < 60) begin
        cnt++;
        check("hold_hi", hi, exp_hi);
        check("hold_lo", lo, exp_lo);
        if (inject && cnt == 2) begin
          start = 1'b1; op = 4'($urandom_range(1, 8));
        end else begin
          start = 1'b0; op = 4'd0;
        end
        a = $urandom; b = $urandom;
        @(posedge clk); #1;
      end
      start = 1'b0; op = 4'd0;
      check("busy_len", 32'(cnt), 32'(n));
    end
    exp_hi = nh; exp_lo = nl;
    check("res_hi", hi, exp_hi);
    check("res_lo", lo, exp_lo);
    check_rdata();
  endtask

  initial begin
    logic [3:0] ro;
    logic [31:0] ra, rb;
    vectors = 0; miscompares = 0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    reset = 1'b0; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    #10 reset = 1'b1;
    // First rising edge after release accepts immediately
    do_op(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFFE);
    do_op(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check("multu_hi_const", hi, 32'h00000001);
    check("multu_lo_const", lo, 32'hFFFFFFFE);
    do_op(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    check("div_hi_const", hi, 32'hFFFFFFFF);
    do_op(4'd4, 32'd7, 32'd0, 1'b0);
    check("divu0_hi", hi, 32'hFFFFFFFF);
    check("divu0_lo", lo, 32'hFFFFFFFD);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);
    do_op(4'd3, 32'd5, 32'd0, 1'b0);
    // MTLO dropped while a MULT is in flight
    do_op(4'd1, 32'h00001234, 32'h00000100, 1'b0);
    start = 1'b1; op = 4'd1; a = 32'h00000003; b = 32'hFFFFFFFE;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    start = 1'b1; op = 4'd8; a = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    repeat (3) begin
      check("mtlo_drop_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    check("mtlo_drop_done", {31'd0, busy}, 32'd0);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFFA;
    check("mtlo_drop_lo", lo, exp_lo);
    check("mtlo_drop_hi", hi, exp_hi);
    check_rdata();
    // MTHI then reset during a DIV
    do_op(4'd7, 32'hDEADBEEF, 32'd0, 1'b0);
    check("mthi_const", hi, 32'hDEADBEEF);
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    #4 reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);
    // Randomized traffic, occasionally with special operands and dropped starts
    for (int i = 0; i < 80; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(ro, ra, rb, ($urandom_range(0, 1) == 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
